// File: rtl/biriscv_fetchq_pkg.sv
// Shared constants and lane helpers for the fetch queue.
// The top module optionally uses BIRISCV_FETCHQ_BYPASS_EN.
package biriscv_fetchq_pkg;

  localparam int INSTR_W = 32;

  // Number of PC bits addressed inside one fetch group.
  function automatic int lane_ofs(input int lanes);
    return $clog2(lanes * (INSTR_W / 8));
  endfunction

  // Lane k's PC: group-aligned base with the lane index in the word bits.
  function automatic logic [31:0] lane_pc(input logic [31:0] pc, input int ofs, input int k);
    return ((pc >> ofs) << ofs) | (32'(k) << 2);
  endfunction

endpackage

// File: rtl/biriscv_fetchq_ctrl.sv
// Fetch queue control: read/write pointers, occupancy, head retire and accept.
module biriscv_fetchq_ctrl #(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             write_i,
  input  logic [LANES-1:0] head_mask_i,
  input  logic [LANES-1:0] pop_i,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W:0]   level_o,
  output logic             accept_o
);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_retire;

  // Head retires once its last remaining valid lane is popped.
  assign w_retire = (r_level != '0) && (head_mask_i != '0) &&
                    ((head_mask_i & ~pop_i) == '0);
  assign accept_o = (r_level != (PTR_W+1)'(DEPTH));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (write_i)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (PTR_W+1)'(write_i) - (PTR_W+1)'(w_retire);
    end
  end

  assign rd_ptr_o = r_rd_ptr;
  assign wr_ptr_o = r_wr_ptr;
  assign level_o  = r_level;

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Multi-lane instruction fetch queue with per-lane pop and one-cycle flush.
// Define BIRISCV_FETCHQ_BYPASS_EN to forward a push into an empty queue combinationally.
module biriscv_fetch_queue
  import biriscv_fetchq_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 2,
  parameter int INFO_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [31:0]             push_pc_i,
  input  logic [LANES*INSTR_W-1:0] push_instr_i,
  input  logic [LANES-1:0]        push_lane_en_i,
  input  logic                    push_fault_i,
  input  logic [LANES*INFO_W-1:0] push_info_i,
  output logic                    push_accept_o,
  output logic [LANES-1:0]        valid_o,
  output logic [LANES*32-1:0]     pc_o,
  output logic [LANES*INSTR_W-1:0] instr_o,
  output logic [LANES*INFO_W-1:0] info_o,
  input  logic [LANES-1:0]        pop_i,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OFS   = lane_ofs(LANES);

  typedef struct packed {
    logic [31:0]              pc;
    logic [LANES*INSTR_W-1:0] instr;
    logic [LANES*INFO_W-1:0]  info;
    logic [LANES-1:0]         mask;
  } entry_t;

  entry_t                   r_mem [DEPTH];
  entry_t                   w_head;
  logic [PTR_W-1:0]         w_rd_ptr;
  logic [PTR_W-1:0]         w_wr_ptr;
  logic [PTR_W:0]           w_level;
  logic                     w_accept;
  logic [LANES-1:0]         w_push_mask;
  logic [LANES-1:0]         w_store_mask;
  logic [LANES-1:0]         w_pop_eff;
  logic [LANES*INSTR_W-1:0] w_push_instr;
  logic                     w_commit;
  logic                     w_bypass;
  logic                     w_write;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_push_mask = '0;
    for (int k = 0; k < LANES; k++)
      w_push_mask[k] = push_lane_en_i[k] && (32'(k) >= ((push_pc_i >> 2) & 32'(LANES-1)));
  end

  assign w_push_instr = push_fault_i ? '0 : push_instr_i;
  assign w_commit     = push_i && w_accept && !flush_i && (w_push_mask != '0);
  assign w_head       = r_mem[w_rd_ptr];

`ifdef BIRISCV_FETCHQ_BYPASS_EN
  assign w_bypass = w_commit && (w_level == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Lanes consumed straight off the bypass path never reach storage.
  assign w_store_mask = w_bypass ? (w_push_mask & ~pop_i) : w_push_mask;
  assign w_write      = w_commit && (w_store_mask != '0);
  assign w_pop_eff    = pop_i & valid_o;

  always_comb begin
    valid_o = '0;
    instr_o = w_head.instr;
    info_o  = w_head.info;
    for (int k = 0; k < LANES; k++) pc_o[k*32 +: 32] = w_head.pc;
    if (w_bypass) begin
      valid_o = w_push_mask;
      instr_o = w_push_instr;
      info_o  = push_info_i;
      for (int k = 0; k < LANES; k++) pc_o[k*32 +: 32] = lane_pc(push_pc_i, OFS, k);
    end else if (w_level != '0) begin
      valid_o = w_head.mask;
      for (int k = 0; k < LANES; k++) pc_o[k*32 +: 32] = lane_pc(w_head.pc, OFS, k);
    end
  end

  // NOTE: storage is reset so the outputs read zero out of reset; flush only clears mask and info.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].mask <= '0;
        r_mem[i].info <= '0;
      end
    end else begin
      if (!w_bypass && (w_level != '0) && (w_pop_eff != '0))
        r_mem[w_rd_ptr].mask <= w_head.mask & ~w_pop_eff;
      if (w_write)
        r_mem[w_wr_ptr] <= '{pc: push_pc_i, instr: w_push_instr,
                             info: push_info_i, mask: w_store_mask};
    end
  end

  biriscv_fetchq_ctrl #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .write_i     (w_write),
    .head_mask_i (w_head.mask),
    .pop_i       (w_pop_eff),
    .rd_ptr_o    (w_rd_ptr),
    .wr_ptr_o    (w_wr_ptr),
    .level_o     (w_level),
    .accept_o    (w_accept)
  );

  assign push_accept_o = w_accept;
  assign level_o       = w_level;

endmodule
